// File: rtl/uart_dec_parser.sv
// ASCII decimal line parser between the UART receiver and the FizzBuzz core.
// Turns "digits + CR/LF" lines into WIDTH-bit numbers behind a one-entry valid/ready output register.
module uart_dec_parser #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  output logic             o_num_valid,
  output logic [WIDTH-1:0] o_num,
  input  logic             i_num_ready,
  output logic             o_busy,
  output logic             o_err,
  output logic [1:0]       o_err_code
);

  localparam int AW = WIDTH + 4;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_BAD  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_OVR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] num_r;
  logic             num_valid_r;
  logic             err_r;
  logic [1:0]       err_code_r;

  logic             is_digit_s;
  logic             is_term_s;
  logic [3:0]       digit_s;
  logic [AW-1:0]    acc_ext_s;
  logic [AW-1:0]    acc_next_s;
  logic             overflow_s;
  logic             accept_s;

  // Byte classification and the widened acc*10+d step with its overflow flag.
  always_comb begin
    is_digit_s = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
    is_term_s  = (i_rx_data == 8'h0A) || (i_rx_data == 8'h0D);
    digit_s    = i_rx_data[3:0];
    acc_ext_s  = {4'b0000, acc_r};
    // acc*10 = acc*8 + acc*2; four spare bits always hold (2**WIDTH-1)*10+9.
    acc_next_s = (acc_ext_s << 3) + (acc_ext_s << 1) + {{(AW-4){1'b0}}, digit_s};
    overflow_s = |acc_next_s[AW-1:WIDTH];
    accept_s   = num_valid_r & i_num_ready;
  end

  // Line parser FSM together with the output entry and the error pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= {WIDTH{1'b0}};
      num_r       <= {WIDTH{1'b0}};
      num_valid_r <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else begin
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
      if (accept_s) begin
        num_valid_r <= 1'b0;
      end
      if (i_rx_valid) begin
        case (state_r)
          ST_IDLE: begin
            if (is_digit_s) begin
              acc_r   <= {{(WIDTH-4){1'b0}}, digit_s};
              state_r <= ST_ACCUM;
            end else if (!is_term_s) begin
              err_r      <= 1'b1;
              err_code_r <= ERR_BAD;
              state_r    <= ST_DISCARD;
            end
          end
          ST_ACCUM: begin
            if (is_digit_s) begin
              if (overflow_s) begin
                err_r      <= 1'b1;
                err_code_r <= ERR_OVF;
                state_r    <= ST_DISCARD;
              end else begin
                acc_r <= acc_next_s[WIDTH-1:0];
              end
            end else if (is_term_s) begin
              acc_r   <= {WIDTH{1'b0}};
              state_r <= ST_IDLE;
              // A full entry that is not being accepted keeps its value; the new number is lost.
              if (!num_valid_r || accept_s) begin
                num_r       <= acc_r;
                num_valid_r <= 1'b1;
              end else begin
                err_r      <= 1'b1;
                err_code_r <= ERR_OVR;
              end
            end else begin
              err_r      <= 1'b1;
              err_code_r <= ERR_BAD;
              state_r    <= ST_DISCARD;
            end
          end
          ST_DISCARD: begin
            if (is_term_s) begin
              acc_r   <= {WIDTH{1'b0}};
              state_r <= ST_IDLE;
            end
          end
          default: begin
            acc_r   <= {WIDTH{1'b0}};
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_num_valid = num_valid_r;
  assign o_num       = num_r;
  assign o_err       = err_r;
  assign o_err_code  = err_code_r;
  assign o_busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_dec_parser.sv
// Randomized bench for uart_dec_parser: a line-buffer reference model evaluates
// each received line as text and predicts the outputs after every clock edge.
module tb_uart_dec_parser;

  localparam int WIDTH = 16;
  localparam longint MAXV = (64'd1 << WIDTH) - 64'd1;

  logic             clk;
  logic             rst_n;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             num_valid;
  logic [WIDTH-1:0] num;
  logic             rdy;
  logic             busy;
  logic             err;
  logic [1:0]       err_code;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [7:0] line_q[$];
  bit         dead;
  bit         m_valid;
  longint     m_num;
  bit         m_err;
  int         m_code;

  uart_dec_parser #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_num_valid (num_valid),
    .o_num       (num),
    .i_num_ready (rdy),
    .o_busy      (busy),
    .o_err       (err),
    .o_err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  function automatic bit is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic bit is_term(input logic [7:0] b);
    return (b == 8'h0A) || (b == 8'h0D);
  endfunction

  function automatic longint line_value();
    longint v = 0;
    foreach (line_q[i]) v = v * 10 + longint'(line_q[i] - 8'h30);
    return v;
  endfunction

  task automatic model_reset();
    line_q.delete();
    dead = 1'b0; m_valid = 1'b0; m_num = 0; m_err = 1'b0; m_code = 0;
  endtask

  // Evaluate one clock edge from the inputs the bench is driving.
  task automatic model_edge();
    bit     accept = m_valid && rdy;
    bit     emit = 1'b0;
    longint val = 0;
    m_err = 1'b0; m_code = 0;
    if (rx_valid) begin
      if (is_term(rx_data)) begin
        if (!dead && line_q.size() > 0) begin emit = 1'b1; val = line_value(); end
        line_q.delete();
        dead = 1'b0;
      end else if (is_digit(rx_data)) begin
        if (!dead) begin
          line_q.push_back(rx_data);
          if (line_value() > MAXV) begin m_err = 1'b1; m_code = 2; dead = 1'b1; end
        end
      end else if (!dead) begin
        m_err = 1'b1; m_code = 1; dead = 1'b1;
      end
    end
    if (accept) m_valid = 1'b0;
    if (emit) begin
      if (!m_valid) begin m_valid = 1'b1; m_num = val; end
      else begin m_err = 1'b1; m_code = 3; end
    end
  endtask

  task automatic compare_all();
    chk("valid", 32'(num_valid), 32'(m_valid));
    chk("num",   32'(num),       32'(m_num));
    chk("err",   32'(err),       32'(m_err));
    chk("code",  32'(err_code),  32'(m_code));
    chk("busy",  32'(busy),      32'(dead || line_q.size() > 0));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  task automatic do_reset(input int cycles);
    rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] bad_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (is_digit(b) || is_term(b));
    return b;
  endfunction

  initial begin
    logic [7:0] q[$];
    string      s;
    int         kind, mode, cut;
    bit         do_cut;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rdy = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single number accepted immediately
    rdy = 1'b1;
    step(1'b1, "1");
    chk("t1_busy_on", 32'(busy), 32'd1);
    send_str("5\n");
    chk("t1_num", 32'(num), 32'd15);
    chk("t1_busy_off", 32'(busy), 32'd0);
    step(1'b0, 8'h00);
    chk("t1_valid_drop", 32'(num_valid), 32'd0);

    // 2: held with no ready, extra terminators ignored
    rdy = 1'b0;
    send_str("42\r\n\n");
    repeat (5) step(1'b0, 8'h55);
    chk("t2_hold", 32'(num), 32'd42);
    rdy = 1'b1;
    step(1'b0, 8'h00);
    chk("t2_clear", 32'(num_valid), 32'd0);

    // 3: width boundary
    send_str("65535\n");
    chk("t3_max", 32'(num), 32'd65535);
    send_str("6553");
    step(1'b1, "6");
    chk("t3_ovf", 32'(err_code), 32'd2);
    send_str("\n3\n");
    chk("t3_after", 32'(num), 32'd3);

    // 4: bad char discards the line
    send_str("1a");
    chk("t4_bad", 32'(err_code), 32'd1);
    send_str("2\n7\n");
    chk("t4_next", 32'(num), 32'd7);
    send_str("007\n");
    chk("t4_lead0", 32'(num), 32'd7);

    // 5: overrun, then emit on the accepting edge
    step(1'b0, 8'h00);
    rdy = 1'b0;
    send_str("5\n9\n");
    chk("t5_ovr", 32'(err_code), 32'd3);
    chk("t5_held", 32'(num), 32'd5);
    step(1'b1, "9");
    rdy = 1'b1;
    step(1'b1, 8'h0A);
    chk("t5_swap_num", 32'(num), 32'd9);
    chk("t5_swap_valid", 32'(num_valid), 32'd1);
    step(1'b0, 8'h00);

    // 6: reset mid-line drops the partial number
    send_str("12");
    do_reset(2);
    send_str("3\n");
    chk("t6_num", 32'(num), 32'd3);

    // randomized lines
    for (int ln = 0; ln < 400; ln++) begin
      q.delete();
      kind = $urandom_range(0, 99);
      mode = $urandom_range(0, 2);
      if (kind < 55) begin
        for (int k = 0; k < $urandom_range(1, 6); k++) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
      end else if (kind < 70) begin
        for (int k = 0; k < $urandom_range(0, 4); k++) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
        q.insert($urandom_range(0, q.size()), bad_byte());
      end else if (kind < 85) begin
        s = $sformatf("%0d", 65520 + $urandom_range(0, 30));
        for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
      end
      case ($urandom_range(0, 2))
        0: q.push_back(8'h0A);
        1: begin q.push_back(8'h0D); q.push_back(8'h0A); end
        default: q.push_back(8'h0D);
      endcase
      do_cut = ($urandom_range(0, 39) == 0);
      cut    = $urandom_range(0, q.size() - 1);
      for (int k = 0; k < q.size(); k++) begin
        if (do_cut && k == cut) begin
          do_reset($urandom_range(1, 3));
          break;
        end
        while ($urandom_range(0, 3) == 0) begin
          rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
          step(1'b0, 8'($urandom_range(0, 255)));
        end
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        step(1'b1, q[k]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
